// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns byte/half/word load-store requests from the
// core into one or two word-wide memory beats, with lane alignment, load
// extension, and a bounded wait on grant and read-data handshakes.
module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wbe,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word0_q, word0_d;
  logic [31:0]       word1_q, word1_d;
  logic              err_q, err_d;

  // Loads accept all five encodings; stores only byte/half/word.
  function automatic logic legal_type(input logic we, input logic [2:0] t);
    if (we) return (t >= 3'd1) && (t <= 3'd3);
    else    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wdata_lanes;
  logic        split;
  logic        beat1;
  logic        wait_expired;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Lane placement and load extraction derived from the latched request.
  always_comb begin
    off = addr_q[1:0];
    unique case (type_q)
      3'd1, 3'd4: size_mask = 4'b0001;
      3'd2, 3'd5: size_mask = 4'b0011;
      3'd3:       size_mask = 4'b1111;
      default:    size_mask = 4'b0000;
    endcase
    // Bytes that spill past lane 3 belong to the next word: that is the split.
    lane_mask    = {4'b0000, size_mask} << off;
    split        = |lane_mask[7:4];
    wdata_lanes  = {32'h0, wdata_q} << {off, 3'b000};
    beat1        = (state_q == REQ1);
    wait_expired = (cnt_q == CNT_W'(MAX_WAIT - 1));
    rd_shift     = 32'({word1_q, word0_q} >> {off, 3'b000});
    unique case (type_q)
      3'd1:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd2:    load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd3:    load_ext = rd_shift;
      3'd4:    load_ext = {24'h0, rd_shift[7:0]};
      3'd5:    load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = '0;
    endcase
  end

  // Next-state, request latching, word capture and timeout counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    word0_d = word0_q;
    word1_d = word1_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          type_d  = req_type;
          we_d    = req_we;
          wdata_d = req_wdata;
          word0_d = '0;
          word1_d = '0;
          cnt_d   = '0;
          err_d   = !legal_type(req_we, req_type);
          state_d = legal_type(req_we, req_type) ? REQ0 : DONE;
        end
      end
      REQ0, REQ1: begin
        if (mem_gnt) begin
          cnt_d = '0;
          if (!we_q)                          state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
          else if (state_q == REQ0 && split)  state_d = REQ1;
          else                                state_d = DONE;
        end else if (wait_expired) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT0, WAIT1: begin
        if (mem_rvalid) begin
          cnt_d = '0;
          if (state_q == WAIT0) begin
            word0_d = mem_rdata;
            state_d = split ? REQ1 : DONE;
          end else begin
            word1_d = mem_rdata;
            state_d = DONE;
          end
        end else if (wait_expired) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; memory fields are zero when no request is up.
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_req    = (state_q == REQ0) || (state_q == REQ1);
    mem_addr   = mem_req ? (addr_q[ADDR_W-1:2] + WA_W'(beat1)) : '0;
    mem_we     = mem_req && we_q;
    mem_wbe    = '0;
    mem_wdata  = '0;
    if (mem_we) begin
      mem_wbe   = beat1 ? lane_mask[7:4] : lane_mask[3:0];
      mem_wdata = beat1 ? wdata_lanes[63:32] : wdata_lanes[31:0];
    end
    resp_valid = (state_q == DONE);
    resp_err   = resp_valid && err_q;
    resp_data  = (resp_valid && !err_q && !we_q) ? load_ext : '0;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised bench for mem_access_ctrl: a transaction-level model plans every
// cycle of each access (beats, handshake delays, timeouts) and one compare
// process checks the DUT against that plan each cycle, plus literal checks.
module tb_mem_access_ctrl;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]        req_type = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0]       resp_data, mem_wdata;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_wbe;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle, written only by the driver.
  logic              e_ready, e_mreq, e_mwe, e_store, e_rvalid, e_rerr;
  logic [ADDR_W-3:0] e_maddr;
  logic [3:0]        e_wbe;
  logic [31:0]       e_wdata, e_rdata;
  bit                chk_en = 1'b0;

  // Literal check requests from the driver, executed by the compare process.
  int          lit_seq = 0, lit_sel = 0;
  string       lit_name = "";
  logic [63:0] lit_exp = '0;

  // Owned by the compare process.
  int          n_total = 0, n_pass = 0, lit_seen = 0;
  int unsigned acc_cyc = 0, last_rcyc = 0, resp_cnt = 0, gnt_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_rerr = 1'b0, ok;
  logic [63:0] act;
  logic [ADDR_W-3:0] prev_addr = '0, last_addr = '0;
  logic [3:0]  prev_wbe = '0, last_wbe = '0;
  logic [31:0] prev_wdata = '0, last_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        ok = (req_ready === e_ready) && (mem_req === e_mreq) && (resp_valid === e_rvalid);
        if (e_mreq)
          ok = ok && (mem_addr === e_maddr) && (mem_we === e_mwe) &&
               (!e_store || ((mem_wbe === e_wbe) && (mem_wdata === e_wdata)));
        if (e_rvalid) ok = ok && (resp_err === e_rerr) && (resp_data === e_rdata);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL cycle %0d: ready %b/%b mreq %b/%b maddr %h/%h we %b/%b wbe %b/%b wdata %h/%h rvalid %b/%b err %b/%b rdata %h/%h (actual/required)",
                      cyc, req_ready, e_ready, mem_req, e_mreq, mem_addr, e_maddr, mem_we, e_mwe,
                      mem_wbe, e_wbe, mem_wdata, e_wdata, resp_valid, e_rvalid, resp_err, e_rerr,
                      resp_data, e_rdata);
      end
      if (rst_n && req_valid && req_ready) acc_cyc = cyc;
      if (rst_n && resp_valid) begin
        last_rcyc = cyc; last_rdata = resp_data; last_rerr = resp_err; resp_cnt++;
      end
      if (rst_n && mem_req && mem_gnt) begin
        prev_addr = last_addr; prev_wbe = last_wbe; prev_wdata = last_wdata;
        last_addr = mem_addr;  last_wbe = mem_wbe;  last_wdata = mem_wdata;
        gnt_cnt++;
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        case (lit_sel)
          0: act = 64'(last_rdata);
          1: act = 64'(last_rerr);
          2: act = 64'(last_rcyc - acc_cyc);
          3: act = 64'(prev_addr);
          4: act = 64'(prev_wbe);
          5: act = 64'(prev_wdata);
          6: act = 64'(last_addr);
          7: act = 64'(last_wbe);
          8: act = 64'(last_wdata);
          9: act = 64'(gnt_cnt);
          default: act = 64'(resp_cnt);
        endcase
        n_total++;
        if (act === lit_exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", lit_name, act, lit_exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model helpers ----------------
  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal_of(input logic we, input logic [2:0] t);
    return we ? (t >= 3'd1 && t <= 3'd3) : (t >= 3'd1 && t <= 3'd5);
  endfunction

  function automatic logic [31:0] load_result(input logic [2:0] t, input int off,
                                              input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] v;
    v = {w1, w0} >> (8 * off);
    case (t)
      3'd1:    return {{24{v[7]}}, v[7:0]};
      3'd2:    return {{16{v[15]}}, v[15:0]};
      3'd3:    return v[31:0];
      3'd4:    return {24'h0, v[7:0]};
      3'd5:    return {16'h0, v[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int pick_delay();
    return ($urandom_range(0, 11) == 0) ? MAX_WAIT + 3 : int'($urandom_range(0, 2));
  endfunction

  task automatic exp_idle(input logic rdy);
    e_ready = rdy; e_mreq = 1'b0; e_mwe = 1'b0; e_store = 1'b0; e_maddr = '0;
    e_wbe = '0; e_wdata = '0; e_rvalid = 1'b0; e_rerr = 1'b0; e_rdata = '0;
  endtask

  task automatic stray_rv();
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom); req_we = 1'($urandom); req_type = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0; mem_gnt = 1'($urandom); stray_rv(); exp_idle(1'b1);
      @(negedge clk);
    end
  endtask

  task automatic lit(input int sel, input string name, input logic [63:0] exp);
    lit_sel = sel; lit_name = name; lit_exp = exp; lit_seq++;
    idle(1);
  endtask

  // Plays one access cycle by cycle: memory behaviour from the given delays,
  // expected outputs from the access rules. Starts and ends at a negedge.
  task automatic run_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                         input int g0, input int r0, input int g1, input int r1);
    int off, nb, k;
    bit legal, to, fin;
    logic [7:0]  bytes;
    logic [63:0] sh;
    logic [ADDR_W-3:0] wa [2];
    int gd [2];
    int rd [2];
    logic [31:0] wv [2];
    logic [31:0] exp_d;
    off   = int'(addr[1:0]);
    legal = legal_of(we, typ);
    nb    = (legal && (off + size_of(typ) > 4)) ? 2 : 1;
    bytes = 8'(((1 << size_of(typ)) - 1) << off);
    sh    = {32'h0, wd} << (8 * off);
    wa[0] = addr[31:2];
    wa[1] = wa[0] + 30'd1;
    gd[0] = g0; gd[1] = g1; rd[0] = r0; rd[1] = r1; wv[0] = w0; wv[1] = w1;
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wd;
    mem_gnt = 1'($urandom); stray_rv(); exp_idle(1'b1);
    @(negedge clk);
    to = 1'b0;
    if (legal) begin
      for (int b = 0; b < nb && !to; b++) begin
        k = 0; fin = 1'b0;
        while (!fin) begin
          junk_req(); exp_idle(1'b0);
          e_mreq = 1'b1; e_maddr = wa[b]; e_mwe = we; e_store = we;
          e_wbe   = (b == 0) ? bytes[3:0] : bytes[7:4];
          e_wdata = (b == 0) ? sh[31:0] : sh[63:32];
          mem_gnt = (k == gd[b]); stray_rv();
          @(negedge clk);
          if (k == gd[b]) fin = 1'b1;
          else if (k == MAX_WAIT - 1) begin fin = 1'b1; to = 1'b1; end
          k++;
        end
        if (!to && !we) begin
          k = 0; fin = 1'b0;
          while (!fin) begin
            junk_req(); exp_idle(1'b0);
            mem_gnt = 1'b0; mem_rvalid = (k == rd[b]);
            mem_rdata = mem_rvalid ? wv[b] : $urandom;
            @(negedge clk);
            if (k == rd[b]) fin = 1'b1;
            else if (k == MAX_WAIT - 1) begin fin = 1'b1; to = 1'b1; end
            k++;
          end
        end
      end
    end
    exp_d = 32'h0;
    if (legal && !to && !we) exp_d = load_result(typ, off, wv[0], (nb == 2) ? wv[1] : 32'h0);
    junk_req(); exp_idle(1'b0);
    e_rvalid = 1'b1; e_rerr = !legal || to; e_rdata = exp_d;
    mem_gnt = 1'($urandom); stray_rv();
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int unsigned mark;
  logic [2:0]  r_typ;
  logic [31:0] r_addr;

  initial begin
    exp_idle(1'b1);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    // Release reset and present a request in the same half-cycle: it must be
    // taken on the very next rising edge.
    rst_n = 1'b1;
    run_txn(1'b0, 3'd3, 32'h100, 32'h0, 32'h8899AABB, 32'h0, 0, 0, 0, 0);
    lit(0, "lw_data", 64'h8899AABB);
    lit(2, "lw_latency", 64'd3);
    lit(6, "lw_mem_addr", 64'h40);

    run_txn(1'b0, 3'd1, 32'h103, 32'h0, 32'h80000000, 32'h0, 1, 2, 0, 0);
    lit(0, "lb_data", 64'hFFFFFF80);
    run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80000000, 32'h0, 0, 0, 0, 0);
    lit(0, "lbu_data", 64'h00000080);

    mark = gnt_cnt;
    run_txn(1'b0, 3'd2, 32'h203, 32'h0, 32'hAB000000, 32'h000000CD, 0, 0, 2, 1);
    lit(0, "lh_split_data", 64'hFFFFCDAB);
    lit(3, "lh_beat0_addr", 64'h80);
    lit(6, "lh_beat1_addr", 64'h81);
    lit(9, "lh_two_reads", 64'(mark + 2));

    run_txn(1'b1, 3'd3, 32'h101, 32'h11223344, 32'h0, 32'h0, 0, 0, 1, 0);
    lit(3, "sw_beat0_addr", 64'h40);
    lit(4, "sw_beat0_wbe", 64'b1110);
    lit(5, "sw_beat0_wdata", 64'h22334400);
    lit(6, "sw_beat1_addr", 64'h41);
    lit(7, "sw_beat1_wbe", 64'b0001);
    lit(8, "sw_beat1_wdata", 64'h00000011);

    run_txn(1'b0, 3'd3, 32'h300, 32'h0, 32'h0, 32'h0, MAX_WAIT + 5, 0, 0, 0);
    lit(1, "gnt_timeout_err", 64'd1);
    lit(0, "gnt_timeout_data", 64'd0);
    lit(2, "gnt_timeout_latency", 64'(MAX_WAIT + 1));

    mark = gnt_cnt;
    run_txn(1'b0, 3'd6, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    lit(1, "illegal_err", 64'd1);
    lit(2, "illegal_latency", 64'd1);
    lit(9, "illegal_no_traffic", 64'(mark));

    // Reset pulse while waiting for read data: outputs go idle before any edge.
    mark = resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'd3; req_addr = 32'h100; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; exp_idle(1'b1);
    @(negedge clk);
    req_valid = 1'b0; exp_idle(1'b0);
    e_mreq = 1'b1; e_maddr = 30'h40; e_mwe = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; mem_gnt = 1'b0; exp_idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    idle(3);
    lit(10, "reset_no_resp", 64'(mark));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) r_typ = 3'($urandom);
      else r_typ = 3'($urandom_range(1, 5));
      r_addr = $urandom;
      if ($urandom_range(0, 7) == 0) r_addr[31:2] = '1;
      run_txn(1'($urandom), r_typ, r_addr, $urandom, $urandom, $urandom,
              pick_delay(), pick_delay(), pick_delay(), pick_delay());
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
